// File: rtl/count_compare_seq.sv
// Count/compare sequencer: walks a programmable table of compare values with one up-counter,
// pulsing step_pulse per entry and done after the last. Optional replay mode via CCS_LOOP_EN.
module count_compare_seq #(
  parameter  int NBITS = 8,
  parameter  int DEPTH = 4,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDXW-1:0]  wr_addr,
  input  logic [NBITS-1:0] wr_data,
  input  logic [IDXW:0]    len,
  input  logic             start,
  input  logic             abort,
`ifdef CCS_LOOP_EN
  input  logic             loop,
`endif
  output logic             busy,
  output logic [NBITS-1:0] count,
  output logic             step_pulse,
  output logic [IDXW-1:0]  match_idx,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [IDXW:0] DEPTH_L = (IDXW+1)'(DEPTH);
  localparam logic [IDXW:0] ONE_L   = (IDXW+1)'(1);

  state_e           state_q, state_d;
  logic [NBITS-1:0] table_q [DEPTH];
  logic [NBITS-1:0] table_d [DEPTH];
  logic [NBITS-1:0] count_q, count_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [IDXW-1:0]  match_idx_q, match_idx_d;
  logic [IDXW:0]    len_q, len_d;
  logic             busy_q, busy_d;
  logic             step_pulse_q, step_pulse_d;
  logic             done_q, done_d;
  logic [IDXW:0]    len_clip_s;
  logic             hit_s;
  logic             last_s;
  logic             replay_s;

`ifdef CCS_LOOP_EN
  logic             loop_q, loop_d;
  assign replay_s = loop_q;
`else
  assign replay_s = 1'b0;
`endif

  assign len_clip_s = (len > DEPTH_L) ? DEPTH_L : len;
  assign hit_s      = (count_q == table_q[idx_q]);
  assign last_s     = ({1'b0, idx_q} == (len_q - ONE_L));

  // Next-state and next-output computation for the sequencer
  always_comb begin
    state_d      = state_q;
    table_d      = table_q;
    count_d      = count_q;
    idx_d        = idx_q;
    match_idx_d  = match_idx_q;
    len_d        = len_q;
    busy_d       = busy_q;
    step_pulse_d = 1'b0;
    done_d       = 1'b0;
`ifdef CCS_LOOP_EN
    loop_d       = loop_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (wr_en) begin
          table_d[wr_addr] = wr_data;
        end else begin
          table_d = table_q;
        end
        if (start && !abort) begin
          len_d   = len_clip_s;
          idx_d   = '0;
          count_d = '0;
`ifdef CCS_LOOP_EN
          loop_d  = loop;
`endif
          // A zero-length request skips RUN and reports completion immediately
          if (len_clip_s != '0) begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end else begin
          busy_d = 1'b0;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          count_d = '0;
          idx_d   = '0;
          busy_d  = 1'b0;
        end else if (hit_s) begin
          count_d      = '0;
          step_pulse_d = 1'b1;
          match_idx_d  = idx_q;
          if (last_s) begin
            idx_d  = '0;
            done_d = 1'b1;
            // In replay mode the table restarts and the sequencer stays busy
            if (replay_s) begin
              state_d = S_RUN;
              busy_d  = 1'b1;
            end else begin
              state_d = S_DONE;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
          end
        end else begin
          count_d = count_q + {{(NBITS-1){1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, table and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      for (int i = 0; i < DEPTH; i++) begin
        table_q[i] <= '0;
      end
      count_q      <= '0;
      idx_q        <= '0;
      match_idx_q  <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      done_q       <= 1'b0;
`ifdef CCS_LOOP_EN
      loop_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      table_q      <= table_d;
      count_q      <= count_d;
      idx_q        <= idx_d;
      match_idx_q  <= match_idx_d;
      len_q        <= len_d;
      busy_q       <= busy_d;
      step_pulse_q <= step_pulse_d;
      done_q       <= done_d;
`ifdef CCS_LOOP_EN
      loop_q       <= loop_d;
`endif
    end
  end

  assign busy       = busy_q;
  assign count      = count_q;
  assign step_pulse = step_pulse_q;
  assign match_idx  = match_idx_q;
  assign done       = done_q;

endmodule

// File: tb/tb_count_compare_seq.sv
// Self-checking bench for count_compare_seq: table-driven sequences plus hand-written
// abort/write/extreme cases; expected step/done events are queued by cycle number.
module tb_count_compare_seq;

  localparam int NBITS = 8;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] len;
  logic       start;
  logic       abort;
`ifdef CCS_LOOP_EN
  logic       loop;
`endif
  logic       busy;
  logic [7:0] count;
  logic       step_pulse;
  logic [1:0] match_idx;
  logic       done;

  count_compare_seq #(.NBITS(NBITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .len(len), .start(start), .abort(abort),
`ifdef CCS_LOOP_EN
    .loop(loop),
`endif
    .busy(busy), .count(count), .step_pulse(step_pulse), .match_idx(match_idx), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit step;
    bit done;
    int idx;
  } ev_t;

  typedef struct packed {
    logic [3:0][7:0]  v;
    logic [2:0]       len;
    logic [2:0]       n;
    logic [3:0][15:0] off;
  } vec_t;

  ev_t  sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  bit   busy_seen = 1'b0;
  vec_t vecs[6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Scoreboard: every cycle either matches the queued event or must be quiet
  always @(negedge clk) begin
    ev_t e;
    if (busy) busy_seen = 1'b1;
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        chk("missed_event_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end else if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("step_pulse", int'(step_pulse), int'(e.step));
        chk("done", int'(done), int'(e.done));
        if (e.step) chk("match_idx", int'(match_idx), e.idx);
      end else begin
        chk("no_step_pulse", int'(step_pulse), 0);
        chk("no_done", int'(done), 0);
      end
    end
  end

  function automatic vec_t mk(input int v0, v1, v2, v3, l, n, o0, o1, o2, o3);
    vec_t r;
    r.v[0] = 8'(v0); r.v[1] = 8'(v1); r.v[2] = 8'(v2); r.v[3] = 8'(v3);
    r.len = 3'(l); r.n = 3'(n);
    r.off[0] = 16'(o0); r.off[1] = 16'(o1); r.off[2] = 16'(o2); r.off[3] = 16'(o3);
    return r;
  endfunction

  task automatic push_ev(input int c, input bit s, input bit d, input int i);
    ev_t e;
    e.cyc = c; e.step = s; e.done = d; e.idx = i;
    sb.push_back(e);
  endtask

  task automatic write_entry(input int a, input int d);
    wr_en = 1'b1; wr_addr = 2'(a); wr_data = 8'(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic load_table(input logic [3:0][7:0] v);
    for (int i = 0; i < 4; i++) write_entry(i, int'(v[i]));
  endtask

  task automatic start_run(input int l);
    start = 1'b1; len = 3'(l);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_empty(input int budget, input string nm);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk(nm, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int k;
    int bad;
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0; abort = 1'b0;
`ifdef CCS_LOOP_EN
    loop = 1'b0;
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Random activity with a non-zero table, then reset held for three cycles
    load_table({8'd8, 8'd7, 8'd6, 8'd5});
    for (int i = 0; i < 20; i++) begin
      wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 8'($urandom);
      start = 1'($urandom); len = 3'($urandom); abort = 1'($urandom_range(0, 7) == 0);
      @(negedge clk);
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'($urandom); wr_addr = 2'($urandom); wr_data = 8'($urandom);
      start = 1'($urandom); len = 3'($urandom); abort = 1'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; wr_en = 1'b0; start = 1'b0; abort = 1'b0; len = '0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_step_pulse", int'(step_pulse), 0);
    chk("rst_match_idx", int'(match_idx), 0);
    chk("rst_done", int'(done), 0);
    mon_en = 1'b1;

    // Cleared table: every step completes on its first RUN cycle
    k = cyc;
    for (int j = 0; j < 4; j++) push_ev(k + 2 + j, 1'b1, j == 3, j);
    start_run(4);
    wait_empty(50, "rst_table_seq");

    vecs[0] = mk(3, 0, 5, 1, 4, 4, 4, 5, 11, 13);
    vecs[1] = mk(0, 0, 0, 0, 7, 4, 1, 2, 3, 4);
    vecs[2] = mk(2, 7, 1, 4, 2, 2, 3, 11, 0, 0);
    vecs[3] = mk(9, 9, 9, 9, 0, 0, 0, 0, 0, 0);
    vecs[4] = mk(1, 1, 1, 1, 3, 3, 2, 4, 6, 0);
    vecs[5] = mk(10, 0, 3, 0, 1, 1, 11, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      load_table(vecs[i].v);
      busy_seen = 1'b0;
      k = cyc;
      if (vecs[i].n == 3'd0) push_ev(k + 1, 1'b0, 1'b1, 0);
      for (int j = 0; j < int'(vecs[i].n); j++)
        push_ev(k + 1 + int'(vecs[i].off[j]), 1'b1, j == int'(vecs[i].n) - 1, j);
      start_run(int'(vecs[i].len));
      wait_empty(300, "vec_seq_complete");
      @(negedge clk);
      chk("vec_busy_after", int'(busy), 0);
      chk("vec_count_after", int'(count), 0);
      if (vecs[i].n == 3'd0) chk("len0_busy_never", int'(busy_seen), 0);
    end

    // Abort mid-count: no step, no done, back to idle with count cleared
    load_table({8'd0, 8'd0, 8'd0, 8'd20});
    start_run(1);
    for (int i = 0; i < 40 && count != 8'd10; i++) @(negedge clk);
    chk("abort_count_reached", int'(count), 10);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_count", int'(count), 0);
    repeat (30) @(negedge clk);

    // Abort on the exact match cycle beats the step
    write_entry(0, 3);
    start_run(1);
    for (int i = 0; i < 20 && count != 8'd3; i++) @(negedge clk);
    chk("abort_match_count", int'(count), 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_match_busy", int'(busy), 0);
    repeat (10) @(negedge clk);

    // Writes while busy are dropped for this run and the next
    write_entry(0, 20);
    k = cyc;
    push_ev(k + 22, 1'b1, 1'b1, 0);
    start_run(1);
    repeat (3) @(negedge clk);
    write_entry(0, 2);
    wait_empty(60, "busy_write_run1");
    k = cyc;
    push_ev(k + 22, 1'b1, 1'b1, 0);
    start_run(1);
    wait_empty(60, "busy_write_run2");

    // Write accepted in the same cycle as start
    k = cyc;
    push_ev(k + 11, 1'b1, 1'b1, 0);
    wr_en = 1'b1; wr_addr = 2'd0; wr_data = 8'd9;
    start_run(1);
    wr_en = 1'b0;
    wait_empty(40, "write_with_start");

    // Largest compare value: 255 counts without wrapping
    write_entry(0, 255);
    k = cyc;
    push_ev(k + 257, 1'b1, 1'b1, 0);
    start_run(1);
    bad = 0;
    for (int n = 0; n < 256; n++) begin
      if (count != 8'(n)) bad++;
      @(negedge clk);
    end
    chk("max_count_ramp_errors", bad, 0);
    wait_empty(10, "max_value_seq");

    // start held high: back-to-back sequences through DONE and IDLE
    write_entry(0, 1);
    k = cyc;
    push_ev(k + 3, 1'b1, 1'b1, 0);
    push_ev(k + 7, 1'b1, 1'b1, 0);
    start = 1'b1; len = 3'd1;
    repeat (5) @(negedge clk);
    start = 1'b0;
    wait_empty(20, "back_to_back");

`ifdef CCS_LOOP_EN
    // Replay mode: table {1,2} repeats every 5 cycles until abort
    load_table({8'd0, 8'd0, 8'd2, 8'd1});
    k = cyc;
    for (int r = 0; r < 3; r++) begin
      push_ev(k + 1 + 5 * r + 2, 1'b1, 1'b0, 0);
      push_ev(k + 1 + 5 * r + 5, 1'b1, 1'b1, 1);
    end
    loop = 1'b1;
    start_run(2);
    loop = 1'b0;
    wait_empty(40, "loop_replay");
    chk("loop_busy_held", int'(busy), 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("loop_abort_busy", int'(busy), 0);
    repeat (10) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/count_compare_seq.md
Name: count_compare_seq

Overview:
Sequencer for the count/compare datapath. It holds a small programmable table of compare values and one NBITS up-counter. On start it walks the table: it counts from 0 until the count equals the current entry, pulses a step event, reloads the counter, and advances to the next entry. It signals done after the last programmed step. It sits between a host/config interface and downstream logic that needs a programmed sequence of timed events.

Parameters:
NBITS, 8, width of the counter and of each compare value
DEPTH, 4, number of table entries (power of 2, >=2); localparam IDXW = $clog2(DEPTH)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
wr_en  input  1  table write strobe
wr_addr  input  IDXW  table entry index
wr_data  input  NBITS  compare value to store
len  input  IDXW+1  number of steps to run (0..DEPTH), sampled on accepted start
start  input  1  start request (level, sampled each cycle)
abort  input  1  cancel a running sequence
busy  output  1  sequence in progress
count  output  NBITS  current counter value
step_pulse  output  1  one-cycle pulse per completed step
match_idx  output  IDXW  index of the step completed; valid while step_pulse=1
done  output  1  one-cycle pulse at end of sequence

Behaviour:
- Reset (rst=1 at edge): state IDLE; busy=0, count=0, step_pulse=0, match_idx=0, done=0; all table entries=0; latched length=0, idx=0. rst overrides all other inputs.
- States: IDLE, RUN, DONE.
- Table writes: accepted only in IDLE (busy=0); take effect next edge; ignored while busy. A write in the same cycle as an accepted start is accepted (state is still IDLE).
- IDLE: on start=1 and abort=0, latch L=min(len,DEPTH), idx=0, count=0.
  - If L>0: go to RUN, busy=1 from the next cycle.
  - If L==0: go to DONE directly; busy stays 0.
- RUN, each cycle:
  - If count==table[idx]: next edge count<=0, step_pulse<=1, match_idx<=idx. Then, if idx==L-1, go to DONE; else idx<=idx+1.
  - Otherwise count<=count+1 and step_pulse<=0.
- Step timing: entry value V completes V+1 cycles after the step begins. V=0 completes on the first RUN cycle of that step. V=2^NBITS-1 matches before overflow, so the counter never wraps.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE. The last step_pulse and done occur in the same cycle. Total latency from the start edge to done = sum over i<L of (table[i]+1) cycles.
- start while busy is ignored. start held high in IDLE re-triggers after DONE, giving back-to-back sequences.
- abort=1 in RUN: go to IDLE on the next edge with count=0, busy=0, no step_pulse and no done. abort wins over a simultaneous match. abort in IDLE blocks a same-cycle start.
- Outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro CCS_LOOP_EN.
- Defined: adds input port loop (1 bit), sampled together with len on accepted start. If loop=1, DONE is not entered after the last step. Instead idx<=0, done pulses for one cycle (together with the last step_pulse), busy stays 1, and the table is replayed until abort. loop=0 behaves as one-shot.
- Undefined: no loop port; always one-shot as described above.

Test Plan:
- Reset: hold rst 3 cycles after random activity -> busy=0, count=0, step_pulse=0, done=0, all table reads 0 (check via L=1 run: step_pulse 1 cycle after RUN entry).
- Basic sequence: table={3,0,5,1}, len=4, start 1 cycle -> step_pulse at cycles 4,5,11,13 after the start edge; match_idx 0,1,2,3; done with the last pulse; busy low after.
- len=0 start -> done pulses 1 cycle after start, busy never 1, no step_pulse. len=7 (>DEPTH=4) -> runs 4 steps only.
- Abort: table={20,..}, len=1, abort at count=10 -> next cycle busy=0, count=0, no step_pulse or done ever. Abort on the exact match cycle -> no step_pulse.
- Writes while busy: write entry0=2 during a run of entry0=20 -> ignored, current and next run use 20. Write in IDLE with simultaneous start (entry0<-9) -> run uses 9.
- Extremes: NBITS=8, entry=255, len=1 -> step_pulse 256 cycles after start, count never wraps to 0 before the match. With CCS_LOOP_EN, loop=1, table={1,2}, len=2 -> step_pulse every 2/3 cycles and done every 5 cycles until abort.
